// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared types for the regfile writeback front end.
// The entry struct depends on module parameters, so it is provided as a macro.
// Each module expands it locally with its own width_p / addr_width values.
`ifndef REGFILE_WB_PKG_SV
`define REGFILE_WB_PKG_SV

`define REGFILE_WB_ENTRY_S(width_mp, addr_width_mp) \
  struct packed { logic [addr_width_mp-1:0] addr; logic [width_mp-1:0] data; }

package regfile_wb_pkg;

  // Which source owns the regfile write port this cycle
  typedef enum logic [1:0] {
    e_wb_none   = 2'd0,
    e_wb_pipe   = 2'd1,
    e_wb_remote = 2'd2
  } wb_src_e;

  // clog2 that never returns 0, so single-element widths stay legal
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

`endif

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: small 1R1W FIFO for remote-load responses.
// Pointers carry a wrap bit so that full and empty are distinguishable at any depth.
// The head is visible combinationally for peek-before-dequeue.
module regfile_wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int addr_width_p = 5,
  parameter int els_p        = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    yumi_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [addr_width_p-1:0] head_addr_o,
  output logic [width_p-1:0]      head_data_o
);

  typedef `REGFILE_WB_ENTRY_S(width_p, addr_width_p) entry_s;

  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam logic [ptr_w_lp-1:0] last_idx_lp = ptr_w_lp'(els_p - 1);

  entry_s              mem [els_p];
  logic [ptr_w_lp-1:0] wr_idx, rd_idx;
  logic                wr_wrap, rd_wrap;
  logic                enq, deq;

  assign full_o  = (wr_idx == rd_idx) & (wr_wrap != rd_wrap);
  assign empty_o = (wr_idx == rd_idx) & (wr_wrap == rd_wrap);
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;

  assign head_addr_o = mem[rd_idx].addr;
  assign head_data_o = mem[rd_idx].data;

  // Storage: no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_idx] <= '{addr: addr_i, data: data_i};
  end

  // Pointer advance, wrapping modulo els_p and toggling the wrap bit
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else begin
      if (enq) begin
        if (wr_idx == last_idx_lp) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (deq) begin
        if (rd_idx == last_idx_lp) begin
          rd_idx  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_idx  <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writeback and buffered remote-load
// responses onto a single regfile write port. The pipeline has fixed priority.
// A committed remote write also pulses a scoreboard clear.
// Optional macro REGFILE_WB_STARVE_GUARD_EN builds the starvation counter.
// That counter drives stall_o. Without the macro, stall_o is tied low.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int fifo_els_p        = 2,
  parameter int starve_limit_p    = 8,
  parameter bit x0_tied_to_zero_p = 1'b1,
  localparam int addr_width_lp    = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pipe_v_i,
  input  logic [addr_width_lp-1:0] pipe_addr_i,
  input  logic [width_p-1:0]       pipe_data_i,
  input  logic                     remote_v_i,
  input  logic [addr_width_lp-1:0] remote_addr_i,
  input  logic [width_p-1:0]       remote_data_i,
  output logic                     remote_ready_o,
  output logic                     stall_o,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,
  output logic                     clear_v_o,
  output logic [addr_width_lp-1:0] clear_addr_o
);

  if (fifo_els_p < 2 || starve_limit_p < 1) begin : g_bad_cfg
    $error("regfile_wb_arbiter: fifo_els_p must be >= 2 and starve_limit_p >= 1");
  end

  logic                     fifo_full, fifo_empty, fifo_yumi;
  logic [addr_width_lp-1:0] head_addr;
  logic [width_p-1:0]       head_data;
  logic                     pipe_eff, head_drop;
  wb_src_e                  grant;

  regfile_wb_fifo #(
    .width_p     (width_p),
    .addr_width_p(addr_width_lp),
    .els_p       (fifo_els_p)
  ) fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (remote_v_i),
    .addr_i     (remote_addr_i),
    .data_i     (remote_data_i),
    .yumi_i     (fifo_yumi),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_addr_o(head_addr),
    .head_data_o(head_data)
  );

  // A dropped x0 pipe write frees the port, so the FIFO head may go instead.
  // An x0 head is still popped, just never written.
  assign pipe_eff       = pipe_v_i & ~(x0_tied_to_zero_p && (pipe_addr_i == '0));
  assign head_drop      = x0_tied_to_zero_p && (head_addr == '0);
  assign fifo_yumi      = ~fifo_empty & ~pipe_eff;
  assign remote_ready_o = ~fifo_full;

  // Fixed-priority grant: pipe first, then a non-discarded FIFO head
  always_comb begin
    grant = e_wb_none;
    if (pipe_eff)                    grant = e_wb_pipe;
    else if (fifo_yumi & ~head_drop) grant = e_wb_remote;
  end

  // Registered write port and scoreboard clear; addr/data hold when idle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_o        <= 1'b0;
      w_addr_o     <= '0;
      w_data_o     <= '0;
      clear_v_o    <= 1'b0;
      clear_addr_o <= '0;
    end else begin
      w_v_o     <= (grant != e_wb_none);
      clear_v_o <= (grant == e_wb_remote);
      if (grant == e_wb_pipe) begin
        w_addr_o <= pipe_addr_i;
        w_data_o <= pipe_data_i;
      end else if (grant == e_wb_remote) begin
        w_addr_o     <= head_addr;
        w_data_o     <= head_data;
        clear_addr_o <= head_addr;
      end
    end
  end

`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam int cnt_w_lp = safe_clog2(starve_limit_p);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(starve_limit_p - 1);

  logic [cnt_w_lp-1:0] starve_cnt;
  logic                stall_r;

  // Count cycles the head is passed over; hold at the limit while stall is up
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_cnt <= '0;
      stall_r    <= 1'b0;
    end else if (fifo_empty | fifo_yumi) begin
      starve_cnt <= '0;
      stall_r    <= 1'b0;
    end else if (starve_cnt == cnt_max_lp) begin
      stall_r    <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_o = stall_r;

  a_no_pipe_during_stall: assert property (@(posedge clk_i) disable iff (reset_i)
    !(stall_o && pipe_v_i))
    else $error("regfile_wb_arbiter: pipe writeback issued while stall_o is high");
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter.
// Directed table, hand-written corner sequences, then random traffic.
// Every cycle is also compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int W   = 16;
  localparam int ELS = 32;
  localparam int FE  = 2;
  localparam int LIM = 8;
  localparam int AW  = 5;
  localparam bit X0  = 1'b1;
`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          pipe_v_i = 1'b0, remote_v_i = 1'b0;
  logic [AW-1:0] pipe_addr_i = '0, remote_addr_i = '0;
  logic [W-1:0]  pipe_data_i = '0, remote_data_i = '0;
  logic          remote_ready_o, stall_o, w_v_o, clear_v_o;
  logic [AW-1:0] w_addr_o, clear_addr_o;
  logic [W-1:0]  w_data_o;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(
    .width_p(W), .els_p(ELS), .fifo_els_p(FE),
    .starve_limit_p(LIM), .x0_tied_to_zero_p(X0)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .remote_v_i(remote_v_i), .remote_addr_i(remote_addr_i), .remote_data_i(remote_data_i),
    .remote_ready_o(remote_ready_o), .stall_o(stall_o),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .clear_v_o(clear_v_o), .clear_addr_o(clear_addr_o)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] addr; logic [W-1:0] data; } ent_t;
  ent_t          q[$];
  int            waited;
  logic          m_wv, m_cv, m_stall;
  logic [AW-1:0] m_wa, m_ca;
  logic [W-1:0]  m_wd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    waited  = 0;
    m_wv    = 1'b0;
    m_cv    = 1'b0;
    m_stall = 1'b0;
    m_wa    = '0;
    m_ca    = '0;
    m_wd    = '0;
  endtask

  // One clock of the spec's rules, applied to the state before the edge
  task automatic model_edge(input logic pv, input logic [AW-1:0] pa, input logic [W-1:0] pd,
                            input logic rv, input logic [AW-1:0] ra, input logic [W-1:0] rd);
    bit   had_head = (q.size() > 0);
    bit   can_take = (q.size() < FE);
    bit   popped   = 1'b0;
    ent_t e;
    m_wv = 1'b0;
    m_cv = 1'b0;
    if (pv && !(X0 && pa == 0)) begin
      m_wv = 1'b1; m_wa = pa; m_wd = pd;
    end else if (had_head) begin
      e = q.pop_front();
      popped = 1'b1;
      if (!(X0 && e.addr == 0)) begin
        m_wv = 1'b1; m_wa = e.addr; m_wd = e.data;
        m_cv = 1'b1; m_ca = e.addr;
      end
    end
    if (rv && can_take) q.push_back('{addr: ra, data: rd});
    if (!had_head || popped) begin
      waited  = 0;
      m_stall = 1'b0;
    end else begin
      waited++;
      if (GUARD && waited >= LIM) m_stall = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("w_v", w_v_o, m_wv);
    chk("clear_v", clear_v_o, m_cv);
    chk("remote_ready", remote_ready_o, q.size() < FE);
    chk("stall", stall_o, m_stall);
    if (m_wv) begin
      chk("w_addr", w_addr_o, m_wa);
      chk("w_data", w_data_o, m_wd);
    end
    if (m_cv) chk("clear_addr", clear_addr_o, m_ca);
  endtask

  task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [W-1:0] pd,
                      input logic rv, input logic [AW-1:0] ra, input logic [W-1:0] rd);
    pipe_v_i = pv;   pipe_addr_i = pa;   pipe_data_i = pd;
    remote_v_i = rv; remote_addr_i = ra; remote_data_i = rd;
    @(posedge clk_i);
    model_edge(pv, pa, pd, rv, ra, rd);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_w_v"}, w_v_o, 0);
    chk({tag, "_w_addr"}, w_addr_o, 0);
    chk({tag, "_w_data"}, w_data_o, 0);
    chk({tag, "_clear_v"}, clear_v_o, 0);
    chk({tag, "_clear_addr"}, clear_addr_o, 0);
    chk({tag, "_ready"}, remote_ready_o, 1);
    chk({tag, "_stall"}, stall_o, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic pv; logic [AW-1:0] pa; logic [W-1:0] pd;
    logic rv; logic [AW-1:0] ra; logic [W-1:0] rd;
    logic ewv; logic [AW-1:0] ewa; logic [W-1:0] ewd;
    logic ecv; logic [AW-1:0] eca; logic erdy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic pv, rv;
    logic [AW-1:0] pa, ra;
    logic [W-1:0] pd, rd;

    //           pv  pa   pd        rv  ra   rd        wv  wa   wd        cv  ca   rdy
    tbl[0]  = '{1'b1, 5'd5, 16'hDEAD, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd5, 16'hDEAD, 1'b0, 5'd0, 1'b1};
    tbl[1]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[2]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 16'h1234, 1'b1, 5'd3, 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'h0077, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[5]  = '{1'b1, 5'd0, 16'h0BAD, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'h0077, 1'b1, 5'd7, 1'b1};
    tbl[6]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 16'h0055, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[8]  = '{1'b1, 5'd0, 16'h1111, 1'b1, 5'd9, 16'h0099, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 1'b1};
    tbl[9]  = '{1'b1, 5'd4, 16'h0444, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd4, 16'h0444, 1'b0, 5'd0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd9, 16'h0099, 1'b1, 5'd9, 1'b1};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset("rst_init");
    model_reset();
    reset_i = 1'b0;

    // Directed table: pipe path, remote path, x0 drop cases
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].rv, tbl[i].ra, tbl[i].rd);
      chk($sformatf("tbl%0d_w_v", i), w_v_o, tbl[i].ewv);
      chk($sformatf("tbl%0d_clear_v", i), clear_v_o, tbl[i].ecv);
      chk($sformatf("tbl%0d_ready", i), remote_ready_o, tbl[i].erdy);
      if (tbl[i].ewv) begin
        chk($sformatf("tbl%0d_w_addr", i), w_addr_o, tbl[i].ewa);
        chk($sformatf("tbl%0d_w_data", i), w_data_o, tbl[i].ewd);
      end
      if (tbl[i].ecv) chk($sformatf("tbl%0d_clear_addr", i), clear_addr_o, tbl[i].eca);
    end

    // FIFO fills under pipe traffic; a third response is held off
    step(1'b1, 5'd1, 16'h0101, 1'b1, 5'd21, 16'h2121);
    step(1'b1, 5'd1, 16'h0102, 1'b1, 5'd22, 16'h2222);
    chk("full_ready", remote_ready_o, 0);
    step(1'b1, 5'd1, 16'h0103, 1'b1, 5'd23, 16'h2323);
    chk("holdoff_ready", remote_ready_o, 0);
    step(1'b0, 5'd0, 16'h0000, 1'b1, 5'd23, 16'h2323);
    chk("holdoff_first_deq", w_addr_o, 21);
    step(1'b0, 5'd0, 16'h0000, 1'b1, 5'd23, 16'h2323);
    idle();
    chk("holdoff_third_commit", clear_addr_o, 23);
    idle();

    // Starvation: one remote entry behind continuous pipe traffic
    step(1'b1, 5'd6, 16'h0600, 1'b1, 5'd20, 16'h2020);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'd6, 16'(i), 1'b0, 5'd0, 16'h0000);
      chk($sformatf("stall_rise%0d", i), stall_o, GUARD && (i == 7));
    end
    step(!m_stall, 5'd6, 16'h0699, 1'b0, 5'd0, 16'h0000);
    chk("stall_fall", stall_o, 0);
    idle();
    idle();

    // Random traffic against the model; pipe honours the modelled stall
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 2) != 0) && !m_stall;
      pa = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom);
      pd = W'($urandom);
      rv = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom);
      rd = W'($urandom);
      step(pv, pa, pd, rv, ra, rd);
    end
    repeat (4) idle();

    // Reset with two entries buffered
    step(1'b1, 5'd2, 16'hAAAA, 1'b1, 5'd11, 16'h0B0B);
    step(1'b1, 5'd2, 16'hAAAB, 1'b1, 5'd12, 16'h0C0C);
    chk("pre_rst_full", remote_ready_o, 0);
    pipe_v_i = 1'b0;
    remote_v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk_reset("rst_mid");
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("post_rst_no_write%0d", i), w_v_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
